// File: rtl/bones_mem_pkg.sv
// Shared types and constants for the AtomBones imem/dmem-to-single-port memory arbiter.
package bones_mem_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned SEL_W  = 4;
   localparam int unsigned CNT_W  = 3;

   localparam logic [SEL_W-1:0] SEL_WORD = 4'hF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ACK   = 2'd3
   } state_e;

   typedef enum logic {
      GNT_IMEM = 1'b0,
      GNT_DMEM = 1'b1
   } gnt_e;

   // Registered memory request payload (address kept separate: its width is a parameter).
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [SEL_W-1:0]  sel;
      logic              we;
   } mem_req_t;

endpackage

// File: rtl/bones_rr_arb2.sv
// Combinational 2-way round-robin grant between imem and dmem requests.
module bones_rr_arb2
   import bones_mem_pkg::*;
(
   input  logic imem_req_i,
   input  logic dmem_req_i,
   input  gnt_e last_grant_i,
   output logic gnt_any_c_o,
   output gnt_e gnt_port_c_o,
   output logic upd_last_c_o
);

   // Only a contended grant rotates the priority pointer.
   always_comb begin
      gnt_any_c_o   = imem_req_i | dmem_req_i;
      upd_last_c_o  = imem_req_i & dmem_req_i;
      gnt_port_c_o  = GNT_IMEM;
      if (imem_req_i && dmem_req_i) begin
         gnt_port_c_o = (last_grant_i == GNT_IMEM) ? GNT_DMEM : GNT_IMEM;
      end else if (dmem_req_i) begin
         gnt_port_c_o = GNT_DMEM;
      end
   end

endmodule

// File: rtl/bones_mem_arbiter.sv
// Merges AtomBones imem/dmem valid/ack ports onto one single-port fixed-latency memory,
// one transaction at a time with round-robin arbitration.
module bones_mem_arbiter
   import bones_mem_pkg::*;
#(
   parameter int unsigned MEM_LATENCY = 1,
   parameter int unsigned ADDR_W      = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [31:0]         imem_addr_i,
   input  logic                imem_valid_i,
   output logic [DATA_W-1:0]   imem_data_o,
   output logic                imem_ack_o,
   input  logic [31:0]         dmem_addr_i,
   input  logic [DATA_W-1:0]   dmem_data_i,
   input  logic [SEL_W-1:0]    dmem_sel_i,
   input  logic                dmem_we_i,
   input  logic                dmem_valid_i,
   output logic [DATA_W-1:0]   dmem_data_o,
   output logic                dmem_ack_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_data_o,
   output logic [SEL_W-1:0]    mem_sel_o,
   output logic                mem_we_o,
   output logic                mem_en_o,
   input  logic [DATA_W-1:0]   mem_data_i
);

   state_e            state_q, state_d;
   gnt_e              gnt_q, gnt_d;
   gnt_e              last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   mem_req_t          req_q, req_d;
   logic              en_q, en_d;
   logic [DATA_W-1:0] irdata_q, irdata_d;
   logic [DATA_W-1:0] drdata_q, drdata_d;
   logic              iack_q, iack_d;
   logic              dack_q, dack_d;

   logic              gnt_any_c;
   gnt_e              gnt_port_c;
   logic              upd_last_c;

   bones_rr_arb2 u_arb (
      .imem_req_i    (imem_valid_i),
      .dmem_req_i    (dmem_valid_i),
      .last_grant_i  (last_q),
      .gnt_any_c_o   (gnt_any_c),
      .gnt_port_c_o  (gnt_port_c),
      .upd_last_c_o  (upd_last_c)
   );

   // Next-state and registered-output logic; strobes and acks default low.
   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      req_d    = req_q;
      en_d     = 1'b0;
      irdata_d = irdata_q;
      drdata_d = drdata_q;
      iack_d   = 1'b0;
      dack_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (gnt_any_c) begin
               gnt_d   = gnt_port_c;
               en_d    = 1'b1;
               state_d = ISSUE;
               if (upd_last_c) begin
                  last_d = gnt_port_c;
               end
               if (gnt_port_c == GNT_DMEM) begin
                  addr_d = ADDR_W'(dmem_addr_i);
                  req_d  = '{data: dmem_data_i, sel: dmem_sel_i, we: dmem_we_i};
               end else begin
                  addr_d = ADDR_W'(imem_addr_i);
                  req_d  = '{data: '0, sel: SEL_WORD, we: 1'b0};
               end
            end
         end
         ISSUE: begin
            cnt_d   = CNT_W'(MEM_LATENCY);
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            // Read data is valid in the cycle the counter shows 1.
            if (cnt_q == CNT_W'(1)) begin
               state_d = ACK;
               if (gnt_q == GNT_DMEM) begin
                  drdata_d = mem_data_i;
                  dack_d   = 1'b1;
               end else begin
                  irdata_d = mem_data_i;
                  iack_d   = 1'b1;
               end
            end
         end
         ACK: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         gnt_q    <= GNT_IMEM;
         last_q   <= GNT_IMEM;
         cnt_q    <= '0;
         addr_q   <= '0;
         req_q    <= '0;
         en_q     <= 1'b0;
         irdata_q <= '0;
         drdata_q <= '0;
         iack_q   <= 1'b0;
         dack_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         req_q    <= req_d;
         en_q     <= en_d;
         irdata_q <= irdata_d;
         drdata_q <= drdata_d;
         iack_q   <= iack_d;
         dack_q   <= dack_d;
      end
   end

   assign imem_data_o = irdata_q;
   assign imem_ack_o  = iack_q;
   assign dmem_data_o = drdata_q;
   assign dmem_ack_o  = dack_q;
   assign mem_addr_o  = addr_q;
   assign mem_data_o  = req_q.data;
   assign mem_sel_o   = req_q.sel;
   assign mem_we_o    = req_q.we;
   assign mem_en_o    = en_q;

endmodule

// File: doc/bones_mem_arbiter.md
Name: bones_mem_arbiter

Overview:
- Sits directly downstream of the AtomBones core ports.
- Merges the core's imem (read-only) and dmem (read/write) valid/ack ports onto one single-port synchronous memory with fixed read latency.
- Lets FPGA SoC targets use one shared block RAM in place of the simulator's separate software memories.
- Round-robin arbitration between the two ports; one transaction in flight at a time.

Parameters:
- MEM_LATENCY, 1, cycles from the mem_en_o cycle to the cycle in which mem_data_i is valid (legal range 1..7).
- ADDR_W, 32, byte-address width passed through to the memory.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- imem_addr_i  in  32  instruction fetch byte address.
- imem_valid_i  in  1  fetch request; held with a stable address until imem_ack_o.
- imem_data_o  out  32  fetched word; valid while imem_ack_o=1.
- imem_ack_o  out  1  one-cycle completion pulse.
- dmem_addr_i  in  32  data byte address.
- dmem_data_i  in  32  store data.
- dmem_sel_i  in  4  byte enables.
- dmem_we_i  in  1  1=store, 0=load.
- dmem_valid_i  in  1  data request; all dmem inputs held stable until dmem_ack_o.
- dmem_data_o  out  32  load data; valid while dmem_ack_o=1.
- dmem_ack_o  out  1  one-cycle completion pulse.
- mem_addr_o  out  ADDR_W  memory byte address.
- mem_data_o  out  32  memory write data.
- mem_sel_o  out  4  memory byte enables.
- mem_we_o  out  1  memory write enable.
- mem_en_o  out  1  memory access strobe; one cycle per transaction.
- mem_data_i  in  32  memory read data.

Behaviour:
- Reset:
  - State returns to IDLE and the latency counter clears.
  - All outputs go to 0: both acks, both data outputs, mem_en_o, mem_we_o, mem_sel_o, mem_addr_o, mem_data_o.
  - last_grant is set to IMEM, so the first contended request goes to dmem.
- FSM states: IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
- IDLE:
  - Samples both valid inputs. If neither is set, stays in IDLE.
  - If only one is set, that port is granted.
  - If both are set, the port that is not last_grant is granted, and last_grant is updated.
  - On a grant, the granted port's address, data, sel and we are registered, and the FSM moves to ISSUE.
- ISSUE:
  - mem_en_o=1 for exactly one cycle, with the registered mem_addr_o, mem_data_o, mem_sel_o and mem_we_o.
  - An imem grant always drives sel=4'b1111 and we=0.
  - The counter loads MEM_LATENCY and the FSM moves to WAIT.
- WAIT:
  - The counter decrements once per cycle.
  - In the cycle where it reaches 1, mem_data_i is captured into the granted port's data register, and the FSM moves to ACK.
- ACK:
  - The granted port's ack is 1 for exactly one cycle. The other ack stays 0.
  - Valid inputs are ignored in this cycle, because the requester still shows the old request.
  - Next state is IDLE.
- Latency and throughput:
  - Valid sampled in cycle N gives mem_en_o in N+1 and ack in N+2+MEM_LATENCY.
  - Maximum throughput is one transaction every MEM_LATENCY+3 cycles.
- Stores use the same timing. dmem_data_o for a store holds the value of mem_data_i captured in the last WAIT cycle; it is don't-care to the core but deterministic.
- Data outputs keep their value after ack until the next completion on that port. They are not cleared.
- mem_addr_o, mem_data_o, mem_sel_o and mem_we_o hold their values after ISSUE. Only mem_en_o qualifies them.
- Protocol violation: if a requester drops valid before its ack, the transaction still completes and the ack pulse is still issued. No abort.
- Reset asserted in any state:
  - The next cycle is IDLE with all outputs 0.
  - An in-flight access is dropped and no ack is produced.
  - The memory may already have performed a write issued in ISSUE.
- No byte-lane shifting or alignment checks; addresses pass through unmodified.

Decomposition:
- Shared package bones_mem_pkg holds:
  - FSM state encoding: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, ACK=2'd3.
  - Grant encoding: GNT_IMEM=1'b0, GNT_DMEM=1'b1.
  - The constant SEL_WORD=4'hF.
- One natural sub-module: bones_rr_arb2, a combinational 2-way round-robin grant with a last_grant input.
- The FSM, request registers and latency counter stay in bones_mem_arbiter.

Test Plan:
- Reset then idle, MEM_LATENCY=1 -> all outputs 0; mem_en_o never asserted over 20 cycles.
- Single imem read, addr 0x0000_0010 valid at cycle 0, memory returns 0xDEADBEEF -> mem_en_o=1 at cycle 1 with mem_addr_o=0x10, sel=4'hF, we=0; imem_ack_o=1 at cycle 3 with imem_data_o=0xDEADBEEF; dmem_ack_o stays 0.
- dmem store, addr 0x8000_0004, data 0x1234_5678, sel 4'b0011, MEM_LATENCY=3 -> mem_en_o=1 at cycle 1 with we=1, sel=4'h3, data 0x12345678; dmem_ack_o pulse at cycle 5 only.
- Both valid simultaneously and held, repeated 4 times -> grants in order dmem, imem, dmem, imem; acks at cycles 3, 7, 11, 15 with MEM_LATENCY=1.
- rst_i pulsed during WAIT of a dmem load, MEM_LATENCY=4 -> no dmem_ack_o; all outputs 0 the cycle after reset; a held request is re-granted from IDLE and acked normally.
- imem_valid_i dropped in WAIT -> imem_ack_o still pulses once; an ack is never asserted for 2 consecutive cycles.
